// File: rtl/bp_pkg.sv
// Shared constants for the 2-bit bimodal/gshare branch predictor.
package bp_pkg;

    localparam int CNT_W = 2;

    typedef enum logic [CNT_W-1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } cnt_state_e;

    localparam logic [CNT_W-1:0] CNT_RESET = WN;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic of one 2-bit saturating branch counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [CNT_W-1:0] state,
    input  logic             taken,
    output logic [CNT_W-1:0] next_state
);

    // Step toward ST on taken, toward SN on not-taken, holding at the ends
    always_comb begin
        next_state = state;
        case (state)
            SN:      next_state = taken ? WN : SN;
            WN:      next_state = taken ? WT : SN;
            WT:      next_state = taken ? ST : WN;
            ST:      next_state = taken ? ST : WT;
            default: next_state = CNT_RESET;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Table of 2-bit counters with EX-stage update and saturating statistics.
// Define BP_GSHARE_EN to XOR a non-speculative global history into the index.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_IF,
    input  logic             btype_IF,
    output logic             branch_predict_IF,
    output logic [IDX_W-1:0] predict_idx_IF,
    input  logic             btype_EX,
    input  logic             stall_EX,
    input  logic [IDX_W-1:0] update_idx_EX,
    input  logic             branch_result_EX,
    input  logic             predict_correct_EX,
    output logic [15:0]      branch_cnt,
    output logic [15:0]      mispredict_cnt
);

    logic [CNT_W-1:0] table_r [ENTRIES];
    logic [CNT_W-1:0] next_cnt_s;
    logic [IDX_W-1:0] pc_idx_s;
    logic             upd_en_s;
    logic [15:0]      branch_cnt_r;
    logic [15:0]      mispredict_cnt_r;
    logic             unused_pc_s;

    assign pc_idx_s    = pc_IF[IDX_W+1:2];
    assign unused_pc_s = ^{pc_IF[31:IDX_W+2], pc_IF[1:0]};
    assign upd_en_s    = btype_EX & ~stall_EX;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_r;

    // History advances only on resolved branches, so it never needs repair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_r <= {IDX_W{1'b0}};
        end else if (upd_en_s) begin
            ghr_r <= {ghr_r[IDX_W-2:0], branch_result_EX};
        end
    end

    assign predict_idx_IF = pc_idx_s ^ ghr_r;
`else
    assign predict_idx_IF = pc_idx_s;
`endif

    // Reads the pre-update table: a same-cycle update is not bypassed
    assign branch_predict_IF = btype_IF & table_r[predict_idx_IF][1] & ~rst;

    sat_counter2 u_sat_counter2 (
        .state      (table_r[update_idx_EX]),
        .taken      (branch_result_EX),
        .next_state (next_cnt_s)
    );

    // Counter table; kept in flops so the whole table clears asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= CNT_RESET;
            end
        end else if (upd_en_s) begin
            table_r[update_idx_EX] <= next_cnt_s;
        end
    end

    // Resolved-branch and mispredict statistics, both sticky at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_r     <= 16'h0000;
            mispredict_cnt_r <= 16'h0000;
        end else if (upd_en_s) begin
            if (branch_cnt_r != 16'hFFFF) begin
                branch_cnt_r <= branch_cnt_r + 16'h0001;
            end
            if (!predict_correct_EX && (mispredict_cnt_r != 16'hFFFF)) begin
                mispredict_cnt_r <= mispredict_cnt_r + 16'h0001;
            end
        end
    end

    assign branch_cnt     = branch_cnt_r;
    assign mispredict_cnt = mispredict_cnt_r;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: Branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, is the pattern-table depth; it SHALL be a power of two, 4..256.
REQ-002 Parameter IDX_W, default $clog2(ENTRIES), is the table index width.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  is the reset: asynchronous, active-high.
REQ-005 pc_IF  input  32  is the fetch PC.
REQ-006 btype_IF  input  1  marks the fetched instruction as a conditional branch.
REQ-007 branch_predict_IF  output  1  is the prediction; 1 = taken.
REQ-008 predict_idx_IF  output  IDX_W  is the table index used; the pipeline carries it to EX.
REQ-009 btype_EX  input  1  marks a branch resolving in EX.
REQ-010 stall_EX  input  1  holds EX; when it is high, no update SHALL occur.
REQ-011 update_idx_EX  input  IDX_W  is the carried index of the EX branch.
REQ-012 branch_result_EX  input  1  is the resolved outcome; 1 = taken.
REQ-013 predict_correct_EX  input  1  is the flush logic's comparison of prediction and result.
REQ-014 branch_cnt  output  16  is the count of resolved branches.
REQ-015 mispredict_cnt  output  16  is the count of mispredicted branches.

Function
REQ-016 The table SHALL hold ENTRIES 2-bit saturating counters: SN=00, WN=01, WT=10, ST=11.
REQ-017 predict_idx_IF SHALL equal pc_IF[IDX_W+1:2], except as modified by REQ-032.
REQ-018 branch_predict_IF SHALL equal btype_IF AND counter[predict_idx_IF][1], combinationally, with zero cycles of latency.
REQ-019 An update SHALL occur when btype_EX=1 and stall_EX=0; the update SHALL take one cycle.
REQ-020 On an update with taken, the counter SHALL move SN->WN->WT->ST and SHALL saturate at ST.
REQ-021 On an update with not-taken, the counter SHALL move ST->WT->WN->SN and SHALL saturate at SN.
REQ-022 When the IF index equals the EX index in the same cycle, the prediction SHALL use the pre-update value; there is no bypass.
REQ-023 On each update, branch_cnt SHALL increment and SHALL saturate at 16'hFFFF.
REQ-024 On each update with predict_correct_EX=0, mispredict_cnt SHALL increment and SHALL saturate at 16'hFFFF.
REQ-025 Entries other than update_idx_EX SHALL be unchanged by an update.

Reset
REQ-026 When rst is asserted, all counters SHALL be set to WN immediately, without waiting for clk.
REQ-027 When rst is asserted, branch_cnt=0, mispredict_cnt=0 and the GHR=0.
REQ-028 While rst is high, branch_predict_IF SHALL be 0.
REQ-029 When rst is asserted during an update, the update SHALL be discarded.
REQ-030 The first clk edge after rst deasserts SHALL perform an update normally.

Configuration
REQ-031 Macro BP_GSHARE_EN SHALL compile in a global history register (GHR) of IDX_W bits.
REQ-032 With BP_GSHARE_EN defined, predict_idx_IF SHALL equal pc_IF[IDX_W+1:2] XOR GHR.
REQ-033 With BP_GSHARE_EN defined, each update SHALL shift GHR left by one, inserting branch_result_EX at bit 0; the GHR is non-speculative.
REQ-034 Without BP_GSHARE_EN, no GHR SHALL exist and indexing SHALL follow REQ-017.

Structure
REQ-035 Package bp_pkg SHALL hold the SN/WN/WT/ST constants, the reset state WN and the counter width.
REQ-036 Sub-module Sat_counter2 SHALL compute the 2-bit next state from the current state and the outcome.
REQ-037 The table SHALL be registers, not a RAM, so that the asynchronous clear in REQ-026 is possible.

Verification
REQ-038 Reset, then btype_IF=1, pc_IF=0x40 -> branch_predict_IF=0 and predict_idx_IF=0.
REQ-039 Three taken updates to idx 0 -> counter goes WN->WT->ST->ST; a pc 0x40 fetch then predicts taken.
REQ-040 Four not-taken updates to idx 3 -> counter reaches SN and stays there; stall_EX=1 with btype_EX=1 -> no change.
REQ-041 Update to idx 5 with a same-cycle fetch of idx 5 (counter at WN, taken) -> the fetch predicts 0 and the next cycle predicts 1.
REQ-042 Load mispredict_cnt with 65535 updates where predict_correct_EX=0, then one more -> value holds at 0xFFFF.
REQ-043 With BP_GSHARE_EN: updates taken, not-taken, taken -> GHR=4'b0101, and pc 0x40 gives predict_idx_IF=5.
